// File: rtl/bp_fe_bp_sched_pkg.sv
// Shared types and constants for the branch-predictor access scheduler.
//   bp_sched_state_e : scheduler FSM state (clear sweep / normal operation)
//   bp_upd_entry_s   : queued commit-time update {idx, correct}; idx is sized
//                      for the widest supported BHT index and narrowed by users
//   stall_cnt_width_gp : width of the lookup-stall performance counter
package bp_fe_bp_sched_pkg;

  typedef enum logic {
    e_init,
    e_run
  } bp_sched_state_e;

  // Widest BHT index an update entry can carry; instantiations must keep
  // bht_idx_width_p at or below this.
  localparam int unsigned bp_upd_idx_width_gp = 16;

  typedef struct packed {
    logic [bp_upd_idx_width_gp-1:0] idx;
    logic                           correct;
  } bp_upd_entry_s;

  localparam int unsigned stall_cnt_width_gp = 16;

endpackage

// File: rtl/bp_fe_bp_upd_fifo.sv
// Circular FIFO buffering commit-time predictor updates.
// Ports:
//   clk_i, reset_n_i : clock, asynchronous active-low reset (empties FIFO)
//   clear_i          : synchronous flush, empties FIFO (wins over push/pop)
//   push_i, data_i   : enqueue (ignored when full)
//   pop_i            : dequeue head (ignored when empty)
//   data_o           : current head entry (zeroed storage, never X)
//   count_o, full_o, empty_o : occupancy status
module bp_fe_bp_upd_fifo #(
  parameter int unsigned width_p = 1,
  parameter int unsigned els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       pop_i,
  output logic [width_p-1:0]         data_o,
  output logic [$clog2(els_p+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned ptr_w = $clog2(els_p);
  localparam int unsigned cnt_w = $clog2(els_p + 1);

  logic [width_p-1:0] mem [els_p];
  logic [ptr_w-1:0]   rd_ptr, wr_ptr;
  logic [cnt_w-1:0]   count;
  logic               do_push, do_pop;

  assign full_o  = (count == cnt_w'(els_p));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < els_p; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_fe_bp_access_sched.sv
// Access scheduler sharing the single predictor table port between front-end
// lookups and buffered commit-time updates, with a clear sweep after reset
// and after every flush.
// Ports:
//   clk_i, reset_n_i        : clock, asynchronous active-low reset
//   flush_i                 : drop queued updates, restart the clear sweep
//   upd_v_i/idx_i/correct_i : update request; upd_ready_o = FIFO has room
//   lkp_v_i/idx_i           : lookup request; lkp_ready_o = granted this cycle
//   init_done_o             : clear sweep finished (registered)
//   bp_w_v_o/idx_w_o/correct_o/clear_o : predictor write port
//   bp_r_v_o/idx_r_o        : predictor read port (combinational from lookup)
//   stall_cnt_o             : lookup-denied cycle counter, only live when
//                             BP_FE_BP_ACCESS_SCHED_PERF_EN is defined
module bp_fe_bp_access_sched
  import bp_fe_bp_sched_pkg::*;
#(
  parameter int unsigned bht_idx_width_p = 2,
  parameter int unsigned upd_fifo_els_p  = 4,
  parameter int unsigned starve_limit_p  = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          flush_i,
  input  logic                          upd_v_i,
  input  logic [bht_idx_width_p-1:0]    upd_idx_i,
  input  logic                          upd_correct_i,
  output logic                          upd_ready_o,
  input  logic                          lkp_v_i,
  input  logic [bht_idx_width_p-1:0]    lkp_idx_i,
  output logic                          lkp_ready_o,
  output logic                          init_done_o,
  output logic                          bp_w_v_o,
  output logic [bht_idx_width_p-1:0]    bp_idx_w_o,
  output logic                          bp_correct_o,
  output logic                          bp_clear_o,
  output logic                          bp_r_v_o,
  output logic [bht_idx_width_p-1:0]    bp_idx_r_o,
  output logic [stall_cnt_width_gp-1:0] stall_cnt_o
);

  localparam int unsigned cnt_w    = $clog2(upd_fifo_els_p + 1);
  localparam int unsigned starve_w = $clog2(starve_limit_p + 1);

  bp_sched_state_e              state;
  logic [bht_idx_width_p-1:0]   sweep_ptr;
  logic                         init_done_r;
  logic [starve_w-1:0]          starve_cnt;

  bp_upd_entry_s                upd_entry, head;
  logic [cnt_w-1:0]             fifo_count;
  logic                         fifo_full, fifo_empty;
  logic                         in_init, in_run, wr_grant, push;

  assign in_init = (state == e_init);
  assign in_run  = (state == e_run);

  assign wr_grant = in_run & ~fifo_empty &
                    (~lkp_v_i | fifo_full | (starve_cnt == starve_w'(starve_limit_p)));

  assign upd_ready_o = reset_n_i & in_run & (fifo_count < cnt_w'(upd_fifo_els_p));
  assign push        = upd_v_i & upd_ready_o & ~flush_i;

  always_comb begin
    upd_entry         = '0;
    upd_entry.idx     = bp_upd_idx_width_gp'(upd_idx_i);
    upd_entry.correct = upd_correct_i;
  end

  bp_fe_bp_upd_fifo #(
    .width_p ($bits(bp_upd_entry_s)),
    .els_p   (upd_fifo_els_p)
  ) upd_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (flush_i),
    .push_i    (push),
    .data_i    (upd_entry),
    .pop_i     (wr_grant),
    .data_o    (head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Outputs are forced low while reset is held, not just after the first edge.
  assign lkp_ready_o  = reset_n_i & in_run & ~wr_grant;
  assign bp_r_v_o     = lkp_ready_o & lkp_v_i;
  assign bp_idx_r_o   = reset_n_i ? lkp_idx_i : '0;
  assign bp_w_v_o     = reset_n_i & (in_init | wr_grant);
  assign bp_clear_o   = reset_n_i & in_init;
  assign bp_idx_w_o   = !reset_n_i ? '0 :
                        in_init    ? sweep_ptr : bht_idx_width_p'(head.idx);
  assign bp_correct_o = reset_n_i & in_run & head.correct;
  assign init_done_o  = init_done_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state       <= e_init;
      sweep_ptr   <= '0;
      init_done_r <= 1'b0;
    end else if (flush_i) begin
      state       <= e_init;
      sweep_ptr   <= '0;
      init_done_r <= 1'b0;
    end else begin
      case (state)
        e_init: begin
          sweep_ptr <= sweep_ptr + 1'b1;
          if (sweep_ptr == '1) begin
            state       <= e_run;
            init_done_r <= 1'b1;
          end
        end
        default: init_done_r <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_cnt <= '0;
    end else if (flush_i || wr_grant || fifo_empty) begin
      starve_cnt <= '0;
    end else if (lkp_v_i && (starve_cnt != starve_w'(starve_limit_p))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

`ifdef BP_FE_BP_ACCESS_SCHED_PERF_EN
  logic [stall_cnt_width_gp-1:0] stall_cnt_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_r <= '0;
    end else if (in_run && lkp_v_i && !lkp_ready_o && (stall_cnt_r != '1)) begin
      stall_cnt_r <= stall_cnt_r + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bp_fe_bp_access_sched.sv
module tb_bp_fe_bp_access_sched;

  logic        clk = 1'b0;
  logic        reset_n, flush;
  logic        upd_v, upd_correct, upd_ready;
  logic [1:0]  upd_idx;
  logic        lkp_v, lkp_ready;
  logic [1:0]  lkp_idx;
  logic        init_done, bp_w_v, bp_correct, bp_clear, bp_r_v;
  logic [1:0]  bp_idx_w, bp_idx_r;
  logic [15:0] stall_cnt;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  bp_fe_bp_access_sched #(
    .bht_idx_width_p (2),
    .upd_fifo_els_p  (4),
    .starve_limit_p  (4)
  ) dut (
    .clk_i         (clk),
    .reset_n_i     (reset_n),
    .flush_i       (flush),
    .upd_v_i       (upd_v),
    .upd_idx_i     (upd_idx),
    .upd_correct_i (upd_correct),
    .upd_ready_o   (upd_ready),
    .lkp_v_i       (lkp_v),
    .lkp_idx_i     (lkp_idx),
    .lkp_ready_o   (lkp_ready),
    .init_done_o   (init_done),
    .bp_w_v_o      (bp_w_v),
    .bp_idx_w_o    (bp_idx_w),
    .bp_correct_o  (bp_correct),
    .bp_clear_o    (bp_clear),
    .bp_r_v_o      (bp_r_v),
    .bp_idx_r_o    (bp_idx_r),
    .stall_cnt_o   (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sweep(input string tag, input int unsigned idx);
    chk({tag, "_w_v"}, bp_w_v, 1);
    chk({tag, "_clear"}, bp_clear, 1);
    chk({tag, "_idx_w"}, bp_idx_w, idx);
    chk({tag, "_correct"}, bp_correct, 0);
    chk({tag, "_done"}, init_done, 0);
    chk({tag, "_lkp_rdy"}, lkp_ready, 0);
    chk({tag, "_upd_rdy"}, upd_ready, 0);
    chk({tag, "_r_v"}, bp_r_v, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] stall_exp;
`ifdef BP_FE_BP_ACCESS_SCHED_PERF_EN
    stall_exp = 2;
`else
    stall_exp = 0;
`endif
    reset_n = 0; flush = 0; upd_v = 0; upd_idx = 0; upd_correct = 0;
    lkp_v = 0; lkp_idx = 0;
    #3;
    chk("rst_w_v", bp_w_v, 0);
    chk("rst_clear", bp_clear, 0);
    chk("rst_done", init_done, 0);
    chk("rst_lkp_rdy", lkp_ready, 0);
    chk("rst_upd_rdy", upd_ready, 0);
    chk("rst_stall", stall_cnt, 0);
    tick;
    reset_n = 1;

    // Clear sweep with lookups requested: never granted, never counted.
    for (int i = 0; i < 4; i++) begin
      lkp_v = 1; lkp_idx = 2'(i);
      #2; chk_sweep("sweep", i);
      tick;
    end
    lkp_idx = 2; #2;
    chk("run_done", init_done, 1);
    chk("run_lkp_rdy", lkp_ready, 1);
    chk("run_r_v", bp_r_v, 1);
    chk("run_idx_r", bp_idx_r, 2);
    chk("run_w_v", bp_w_v, 0);
    chk("run_upd_rdy", upd_ready, 1);
    tick;

    // Idle lookups: update written the cycle after enqueue.
    lkp_v = 0; upd_v = 1; upd_idx = 2; upd_correct = 1; #2;
    chk("idle_enq_w_v", bp_w_v, 0);
    tick;
    upd_v = 0; #2;
    chk("idle_w_v", bp_w_v, 1);
    chk("idle_idx_w", bp_idx_w, 2);
    chk("idle_correct", bp_correct, 1);
    chk("idle_clear", bp_clear, 0);
    chk("idle_lkp_rdy", lkp_ready, 0);
    tick;
    #2; chk("idle_drained", bp_w_v, 0);
    tick;

    // Starvation limit: 4 lookups win, 5th cycle forces the write.
    lkp_v = 1; lkp_idx = 1; upd_v = 1; upd_idx = 3; upd_correct = 0; #2;
    chk("starve_enq_lkp", lkp_ready, 1);
    tick;
    upd_v = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("starve_lkp", lkp_ready, 1);
      chk("starve_no_w", bp_w_v, 0);
      tick;
    end
    #2;
    chk("starve_grant_lkp", lkp_ready, 0);
    chk("starve_grant_w_v", bp_w_v, 1);
    chk("starve_grant_idx", bp_idx_w, 3);
    chk("starve_grant_cor", bp_correct, 0);
    chk("starve_grant_r_v", bp_r_v, 0);
    tick;
    #2;
    chk("starve_resume", lkp_ready, 1);
    chk("starve_resume_w", bp_w_v, 0);
    tick;

    // Fill the FIFO under constant lookups; full forces a write.
    for (int i = 0; i < 4; i++) begin
      upd_v = 1; upd_idx = 2'(i); upd_correct = (i % 2 == 0);
      #2;
      chk("fill_upd_rdy", upd_ready, 1);
      chk("fill_no_w", bp_w_v, 0);
      tick;
    end
    upd_idx = 1; #2;
    chk("full_upd_rdy", upd_ready, 0);
    chk("full_w_v", bp_w_v, 1);
    chk("full_idx", bp_idx_w, 0);
    chk("full_cor", bp_correct, 1);
    chk("full_lkp_rdy", lkp_ready, 0);
    tick;
    upd_v = 0; #2;
    chk("after_full_upd_rdy", upd_ready, 1);
    chk("after_full_lkp", lkp_ready, 1);
    chk("after_full_w_v", bp_w_v, 0);
    tick;
    lkp_v = 0;
    for (int i = 1; i < 4; i++) begin
      #2;
      chk("drain_w_v", bp_w_v, 1);
      chk("drain_idx", bp_idx_w, i);
      chk("drain_cor", bp_correct, (i % 2 == 0));
      tick;
    end
    #2;
    chk("drain_empty", bp_w_v, 0);
    chk("stall_cnt", stall_cnt, stall_exp);
    tick;

    // Flush with 3 queued updates: none may ever be written.
    lkp_v = 1; lkp_idx = 0;
    for (int i = 0; i < 3; i++) begin
      upd_v = 1; upd_idx = 2'(i + 1); upd_correct = 1;
      #2; chk("fl_q_no_w", bp_w_v, 0);
      tick;
    end
    upd_idx = 3; flush = 1; #2;
    chk("fl_cycle_w_v", bp_w_v, 0);
    chk("fl_cycle_lkp", lkp_ready, 1);
    chk("fl_cycle_r_v", bp_r_v, 1);
    tick;
    flush = 0; upd_v = 0; lkp_v = 0;
    for (int i = 0; i < 4; i++) begin
      #2; chk_sweep("fl_sweep", i);
      tick;
    end
    #2;
    chk("fl_done", init_done, 1);
    chk("fl_no_stale_w", bp_w_v, 0);
    tick;

    // Reset asserted mid-sweep at pointer 2.
    flush = 1; #2; tick;
    flush = 0;
    for (int i = 0; i < 2; i++) begin
      #2; chk("mid_idx", bp_idx_w, i);
      tick;
    end
    #2;
    chk("mid_idx2", bp_idx_w, 2);
    reset_n = 0; #1;
    chk("mid_rst_w_v", bp_w_v, 0);
    chk("mid_rst_clear", bp_clear, 0);
    chk("mid_rst_idx", bp_idx_w, 0);
    chk("mid_rst_done", init_done, 0);
    chk("mid_rst_lkp", lkp_ready, 0);
    tick;
    reset_n = 1; #2;
    chk_sweep("re_sweep0", 0);
    chk("re_stall", stall_cnt, 0);
    tick;
    #2; chk_sweep("re_sweep1", 1);
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
